// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start qualification, mid-bit data sampling,
// stop-bit check with one-cycle done / framing-error strobes.
module uart_receiver #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enb,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] doutrx,
    output logic                 donerx,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_meta_q, rx_s_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        if (rx_enb) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = S_IDLE;
                        if (rx_s_q) begin
                            dout_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        doutrx    = dout_q;
        donerx    = done_q;
        frame_err = ferr_q;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive side of the team's UART link and counterpart to the transmitter: 8N1, LSB-first framing, idle-high line.
- Oversamples the serial line using a one-cycle enable tick from the shared baud generator.
- Detects and qualifies the start bit, samples each data bit at mid-bit, and checks the stop bit.
- Delivers the byte with a one-cycle done strobe, or flags a framing error.

Parameters:
- OVERSAMPLE, 16, rx_enb ticks per bit period; must be even, ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_enb  input  1  oversample tick; one clk cycle wide, OVERSAMPLE ticks per bit.
- rx  input  1  serial line, asynchronous to clk, idle high.
- doutrx  output  DATA_BITS  last correctly framed byte; bit 0 is the first bit received.
- donerx  output  1  one-cycle pulse: doutrx updated with a valid byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; tick_cnt=0; bit_cnt=0; shift_reg=0.
  - rx synchronizer flops=1.
  - doutrx=0, donerx=0, frame_err=0, busy=0.
  - Reset mid-frame abandons the frame with no strobe.
- Synchronizer:
  - rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Timing:
  - All state, counter and sample updates happen only in clk cycles where rx_enb=1.
  - With rx_enb=0 everything holds, except donerx/frame_err, which self-clear after one cycle.
- IDLE:
  - tick with rx_s=0 -> START, tick_cnt=0.
- START:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s:
    - 0 -> DATA, tick_cnt=0, bit_cnt=0.
    - 1 -> false start, return to IDLE with no strobe.
- DATA:
  - Each tick increments tick_cnt.
  - On the tick where tick_cnt==OVERSAMPLE-1:
    - shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]} (LSB first).
    - tick_cnt=0, bit_cnt+1.
  - After the DATA_BITS-th sample -> STOP.
- STOP:
  - On the tick where tick_cnt==OVERSAMPLE-1 (mid stop bit), sample rx_s:
    - 1 -> doutrx<=shift_reg; donerx=1 for the next clk cycle.
    - 0 -> frame_err=1 for the next clk cycle; doutrx unchanged.
  - Either way -> IDLE.
  - The next start bit may begin right after mid stop, so back-to-back frames are supported.
- Output latency:
  - donerx/frame_err are registered and assert in the clk cycle after the stop-sample tick.
  - doutrx changes in the same cycle that donerx rises.
- Strobe exclusivity:
  - donerx and frame_err never assert together.
  - Neither asserts outside STOP completion.
- Counter width:
  - tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt is $clog2(DATA_BITS+1) bits.
  - Neither counter wraps inside a frame.
- Illegal state encoding -> IDLE.
- Line stuck low: at most a frame_err per frame time; the block re-arms from IDLE each time. No lockup.

Test Plan:
- Basic frame, rx_enb every 4 clks, OVERSAMPLE=16: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> exactly one donerx pulse; doutrx=0xA5; frame_err never high; busy low after the stop sample.
- Back-to-back: 0x3C then 0xC3 with no idle gap -> two donerx pulses about 160 ticks apart; doutrx=0x3C, then 0xC3.
- Glitch: rx low for 4 ticks, then high -> busy rises then falls before any DATA sample; no donerx, no frame_err; doutrx keeps its previous value.
- Framing error: send 0x55 with stop bit driven 0 -> frame_err pulses once; donerx stays 0; doutrx keeps prior 0xA5. A following valid 0x0F is received correctly.
- Stall: hold rx_enb=0 for 50 clks mid-DATA while rx is stable -> no state or counter change. Resuming ticks completes the frame correctly.
- Reset mid-frame: assert rst during bit 4 of 0xFF -> all outputs 0 immediately. After release, a fresh 0x81 is received correctly with no spurious strobe.
